// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and sizing constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int WORD_BYTES = 8;
  localparam int OFFSET_W   = 3;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage load/store request and response channels
interface dmem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/dmem_storage.sv
// rtl/dmem_storage.sv - byte-lane doubleword array with a read register captured on demand
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic                         rd_clr,
  input  logic [ADDR_W-OFFSET_W-1:0]   idx,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [WORD_BYTES-1:0]        wstrb,
  output logic [DATA_W-1:0]            rdata
);

  localparam int DEPTH = 2 ** (ADDR_W - OFFSET_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents deliberately survive reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wstrb[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (rd_clr) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder; DMEM_MISALIGN_CHECK_EN flags
// unaligned accesses with resp_err instead of silently aligning them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    write_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [WORD_BYTES-1:0]   wstrb_q;
  logic                    err_q, err_d;
  logic                    capture;
  logic                    wr_en;
  logic                    rd_en;
  logic                    rd_clr;
  logic                    misaligned;
  logic [DATA_W-1:0]       rdata;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = (addr_q[OFFSET_W-1:0] != '0);
`else
  logic unused_offset;
  assign unused_offset = ^addr_q[OFFSET_W-1:0];
  assign misaligned    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (capture) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    capture = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ACCESS;
      end
      ACCESS: begin
        wr_en   = write_q  & ~misaligned;
        rd_en   = ~write_q & ~misaligned;
        err_d   = misaligned;
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          rd_clr  = 1'b1;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dmem_storage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_storage (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .rd_clr (rd_clr),
    .idx    (addr_q[ADDR_W-1:OFFSET_W]),
    .wdata  (wdata_q),
    .wstrb  (wstrb_q),
    .rdata  (rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_rdata = rdata;
  assign bus.resp_err   = err_q;

endmodule
